// File: rtl/video_palette_stage.sv
// video_palette_stage
//   Maps the pattern generator's 8-bit colour index to 24-bit RGB through a
//   256-entry palette RAM. It also delays HBlank/HSync/VBlank/VSync so they stay
//   aligned with the colour data.
//   Palette writes from the control side are committed only during VBlank,
//   unless ALLOW_ACTIVE_WR is set. This keeps a frame from being recoloured
//   part way through.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   ce_pix                     pixel enable; the pipeline advances only when high
//   hblank_in..vsync_in        timing from the generator
//   video_in [7:0]             palette index
//   pal_wr_req/addr/data       level write request, held until pal_wr_ack
//   pal_wr_ack                 one-clk pulse when the write has been committed
//   ce_pix_out                 ce_pix delayed 1 clk
//   hblank_out..vsync_out      timing delayed 2 pixel ticks
//   r_out/g_out/b_out          colour, 0 while blanked
//   de_out                     display enable
//   frame_cnt                  vsync rising edges seen since reset
module video_palette_stage #(
  parameter bit ALLOW_ACTIVE_WR = 1'b0,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_pix,
  input  logic                   hblank_in,
  input  logic                   hsync_in,
  input  logic                   vblank_in,
  input  logic                   vsync_in,
  input  logic [7:0]             video_in,
  input  logic                   pal_wr_req,
  input  logic [7:0]             pal_wr_addr,
  input  logic [23:0]            pal_wr_data,
  output logic                   pal_wr_ack,
  output logic                   ce_pix_out,
  output logic                   hblank_out,
  output logic                   hsync_out,
  output logic                   vblank_out,
  output logic                   vsync_out,
  output logic [7:0]             r_out,
  output logic [7:0]             g_out,
  output logic [7:0]             b_out,
  output logic                   de_out,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK, S_WAIT} wr_state_t;

  // The RAM stores each entry XOR {i,i,i}.
  // A zero-initialised array therefore reads back as the grayscale default
  // palette, and no per-entry init table is needed.
  logic [23:0] pal_mem [256] = '{default: 24'h0};

  wr_state_t   state, state_nxt;
  logic [7:0]  wr_addr_q;
  logic [23:0] wr_data_q;
  logic        wr_en, ack_nxt;

  // stage 1
  logic [23:0] pal_q;
  logic [7:0]  idx_q;
  logic        hb1, hs1, vb1, vs1;
  logic        vs_prev;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pal_wr_ack <= 1'b0;
    end else begin
      state      <= state_nxt;
      pal_wr_ack <= ack_nxt;
    end
  end

  // Address and data are captured only at acceptance.
  // Any later change on the request bus is ignored.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && pal_wr_req) begin
      wr_addr_q <= pal_wr_addr;
      wr_data_q <= pal_wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pal_wr_req) state_nxt = S_PEND;
      S_PEND:  if (ALLOW_ACTIVE_WR || vblank_in) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_WAIT;
      S_WAIT:  if (!pal_wr_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en   = (state == S_PEND) && (ALLOW_ACTIVE_WR || vblank_in);
    ack_nxt = (state == S_ACK);
  end

  // The write port is not gated by ce_pix. The read is in a separate block, so
  // a read of the same entry in the same clk returns the old value.
  always_ff @(posedge clk) begin
    if (wr_en) pal_mem[wr_addr_q] <= wr_data_q ^ {3{wr_addr_q}};
  end

  // ---------------- pixel pipeline ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pal_q <= '0;
      idx_q <= '0;
      {hb1, hs1, vb1, vs1} <= '0;
    end else if (ce_pix) begin
      pal_q <= pal_mem[video_in];
      idx_q <= video_in;
      {hb1, hs1, vb1, vs1} <= {hblank_in, hsync_in, vblank_in, vsync_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {r_out, g_out, b_out} <= '0;
      {hblank_out, hsync_out, vblank_out, vsync_out} <= '0;
      de_out <= 1'b0;
    end else if (ce_pix) begin
      {r_out, g_out, b_out} <= (hb1 || vb1) ? 24'h0 : (pal_q ^ {3{idx_q}});
      {hblank_out, hsync_out, vblank_out, vsync_out} <= {hb1, hs1, vb1, vs1};
      de_out <= ~(hb1 | vb1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ce_pix_out <= 1'b0;
    else       ce_pix_out <= ce_pix;
  end

  // ---------------- frame counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev   <= 1'b0;
      frame_cnt <= '0;
    end else if (ce_pix) begin
      vs_prev <= vsync_in;
      if (vsync_in && !vs_prev) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_video_palette_stage.sv
module tb_video_palette_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ce, hb, hs, vb, vs;
  logic [7:0]  vid;
  logic        req0, req1;
  logic [7:0]  addr0, addr1;
  logic [23:0] data0, data1;

  logic        ack0, ceo0, hbo0, hso0, vbo0, vso0, de0;
  logic [7:0]  r0, g0, b0;
  logic [15:0] fc0;
  logic        ack1, ceo1, hbo1, hso1, vbo1, vso1, de1;
  logic [7:0]  r1, g1, b1;
  logic [15:0] fc1;

  video_palette_stage #(.ALLOW_ACTIVE_WR(1'b0), .FRAME_CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .ce_pix(ce),
    .hblank_in(hb), .hsync_in(hs), .vblank_in(vb), .vsync_in(vs), .video_in(vid),
    .pal_wr_req(req0), .pal_wr_addr(addr0), .pal_wr_data(data0), .pal_wr_ack(ack0),
    .ce_pix_out(ceo0), .hblank_out(hbo0), .hsync_out(hso0), .vblank_out(vbo0),
    .vsync_out(vso0), .r_out(r0), .g_out(g0), .b_out(b0), .de_out(de0), .frame_cnt(fc0));

  video_palette_stage #(.ALLOW_ACTIVE_WR(1'b1), .FRAME_CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .ce_pix(ce),
    .hblank_in(hb), .hsync_in(hs), .vblank_in(vb), .vsync_in(vs), .video_in(vid),
    .pal_wr_req(req1), .pal_wr_addr(addr1), .pal_wr_data(data1), .pal_wr_ack(ack1),
    .ce_pix_out(ceo1), .hblank_out(hbo1), .hsync_out(hso1), .vblank_out(vbo1),
    .vsync_out(vso1), .r_out(r1), .g_out(g1), .b_out(b1), .de_out(de1), .frame_cnt(fc1));

  int checks = 0;
  int errors = 0;
  int ack0_cnt = 0;
  int a0;

  always @(posedge clk) if (ack0) ack0_cnt <= ack0_cnt + 1;

  typedef struct {
    logic        hb, hs, vb, vs;
    logic [7:0]  idx;
    logic [23:0] rgb;
    logic        de;
  } vec_t;
  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  initial begin
    vt[0] = '{hb:0, hs:0, vb:0, vs:0, idx:8'h40, rgb:24'h404040, de:1};
    vt[1] = '{hb:0, hs:0, vb:0, vs:0, idx:8'h00, rgb:24'h000000, de:1};
    vt[2] = '{hb:0, hs:0, vb:0, vs:0, idx:8'hFF, rgb:24'hFFFFFF, de:1};
    vt[3] = '{hb:1, hs:0, vb:0, vs:0, idx:8'hFF, rgb:24'h000000, de:0};
    vt[4] = '{hb:1, hs:1, vb:0, vs:0, idx:8'h80, rgb:24'h000000, de:0};
    vt[5] = '{hb:0, hs:0, vb:1, vs:0, idx:8'h20, rgb:24'h000000, de:0};
    vt[6] = '{hb:0, hs:0, vb:1, vs:1, idx:8'h20, rgb:24'h000000, de:0};
    vt[7] = '{hb:0, hs:0, vb:0, vs:0, idx:8'h7F, rgb:24'h7F7F7F, de:1};

    reset = 1; ce = 1; hb = 0; hs = 0; vb = 0; vs = 0; vid = 8'h55;
    req0 = 0; addr0 = 0; data0 = 0; req1 = 0; addr1 = 0; data1 = 0;
    tick(); tick();
    chk("reset_rgb", {8'h0, r0, g0, b0}, 32'h0);
    chk("reset_de", de0, 0);
    chk("reset_fc", fc0, 0);
    chk("reset_ack", ack0, 0);
    reset = 0;

    // steady-state table, ce every clk
    for (int i = 0; i < 8; i++) begin
      hb = vt[i].hb; hs = vt[i].hs; vb = vt[i].vb; vs = vt[i].vs; vid = vt[i].idx;
      tick(); tick();
      chk($sformatf("vec%0d_rgb", i), {8'h0, r0, g0, b0}, {8'h0, vt[i].rgb});
      chk($sformatf("vec%0d_de", i), de0, vt[i].de);
      chk($sformatf("vec%0d_sync", i), {hbo0, hso0, vbo0, vso0},
          {vt[i].hb, vt[i].hs, vt[i].vb, vt[i].vs});
    end

    // exact 2-tick latency of colour and sync
    vid = 8'h40; hs = 1;
    tick();
    chk("lat1_rgb", {8'h0, r0, g0, b0}, 32'h7F7F7F);
    chk("lat1_hs", hso0, 0);
    tick();
    chk("lat2_rgb", {8'h0, r0, g0, b0}, 32'h404040);
    chk("lat2_hs", hso0, 1);
    hs = 0;

    // alternating ce_pix
    vid = 8'h00; tick(); tick();
    vid = 8'h80; ce = 1; tick();
    chk("ce_out_hi", ceo0, 1);
    vid = 8'h11; ce = 0; tick();
    chk("ce_out_lo", ceo0, 0);
    chk("ce_hold0", {8'h0, r0, g0, b0}, 32'h000000);
    ce = 1; tick();
    chk("ce_lat", {8'h0, r0, g0, b0}, 32'h808080);
    vid = 8'h22; ce = 0; tick();
    chk("ce_hold1", {8'h0, r0, g0, b0}, 32'h808080);
    ce = 1; tick();
    chk("ce_next", {8'h0, r0, g0, b0}, 32'h111111);

    // write during active video is deferred to VBlank
    vid = 8'h40; vb = 0;
    req0 = 1; addr0 = 8'h40; data0 = 24'hFF0000;
    a0 = ack0_cnt;
    repeat (10) tick();
    chk("defer_rgb", {8'h0, r0, g0, b0}, 32'h404040);
    chk("defer_noack", ack0_cnt, a0);
    vb = 1; tick();
    chk("vbl_ack_t1", ack0, 0);
    tick();
    chk("vbl_ack_t2", ack0, 1);
    tick();
    chk("vbl_ack_pulse", ack0, 0);
    req0 = 0; vb = 0; tick(); tick();
    chk("new_colour", {8'h0, r0, g0, b0}, 32'hFF0000);

    // held request: one write; post-accept changes ignored
    vb = 1; req0 = 1; addr0 = 8'h41; data0 = 24'h0000FF;
    tick();
    addr0 = 8'h42; data0 = 24'h00FF00;
    tick(); tick();
    chk("held_ack", ack0, 1);
    tick();
    a0 = ack0_cnt;
    repeat (5) tick();
    chk("held_noack", ack0_cnt, a0);
    req0 = 0; tick();
    req0 = 1; addr0 = 8'h42; data0 = 24'h123456;
    tick(); tick(); tick();
    chk("rereq_ack", ack0, 1);
    req0 = 0; tick();
    vb = 0; vid = 8'h41; tick(); tick();
    chk("held_entry41", {8'h0, r0, g0, b0}, 32'h0000FF);
    vid = 8'h42; tick(); tick();
    chk("rereq_entry42", {8'h0, r0, g0, b0}, 32'h123456);

    // frame counter
    reset = 1; tick(); reset = 0;
    chk("fc_reset", fc0, 0);
    repeat (3) begin
      vs = 1; tick(); tick();
      vs = 0; tick(); tick();
    end
    chk("fc_three", fc0, 3);

    // reset while pending drops the write
    vb = 0; req0 = 1; addr0 = 8'h43; data0 = 24'hABCDEF;
    tick();
    reset = 1; tick(); reset = 0; req0 = 0;
    a0 = ack0_cnt;
    vb = 1; repeat (5) tick();
    chk("rst_pend_noack", ack0_cnt, a0);
    vb = 0; vid = 8'h43; tick(); tick();
    chk("rst_pend_entry", {8'h0, r0, g0, b0}, 32'h434343);

    // immediate write variant
    vb = 0; vid = 8'h50;
    req1 = 1; addr1 = 8'h50; data1 = 24'h00FF00;
    tick();
    chk("aw_ack_t1", ack1, 0);
    tick();
    chk("aw_ack_t2", ack1, 0);
    tick();
    chk("aw_ack_t3", ack1, 1);
    req1 = 0; tick(); tick();
    chk("aw_colour", {8'h0, r1, g1, b1}, 32'h00FF00);
    chk("aw_other_dut", {8'h0, r0, g0, b0}, 32'h505050);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
